// File: rtl/aibcr3_dcc_dlyctrl64.sv
// Delay-line calibration controller for a 64-stage DCC delay chain.
// A phase detector result (pd_valid/pd_up) nudges the stage count by one.
// Each code change is followed by a settle window, and samples arriving
// during that window are dropped rather than queued. After enough
// consecutive direction reversals, the loop reports lock.
// Handshake: pd_valid is a one-cycle qualifier with no ready/back-pressure.
// A sample is consumed only in SAMPLE or LOCKED, and dropped otherwise.
module aibcr3_dcc_dlyctrl64 #(
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4,
  parameter int INIT_CODE  = 32
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        enable,
  input  logic        pd_valid,
  input  logic        pd_up,
  output logic [63:0] bk,
  output logic [6:0]  code,
  output logic        lock,
  output logic        at_min,
  output logic        at_max,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] settle_cnt;
  logic [3:0] rev_cnt;
  logic       prev_dir;
  logic       prev_vld;

  logic       sat;
  logic [6:0] code_step;
  logic [3:0] rev_step;

  localparam logic [6:0] INIT_C   = 7'(INIT_CODE);
  localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYC);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);

  // Build the thermometer word: stage i is on when i is below the code.
  function automatic logic [63:0] therm(input logic [6:0] c);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (7'(i) < c);
    return r;
  endfunction

  // Work out the candidate step result for the current sample: the saturated
  // flag, the next code, and the next reversal count.
  always_comb begin
    sat       = pd_up ? (code == 7'd64) : (code == 7'd0);
    code_step = code;
    rev_step  = 4'd0;
    if (!sat) begin
      code_step = pd_up ? 7'(code + 7'd1) : 7'(code - 7'd1);
      if (prev_vld && (prev_dir != pd_up))
        rev_step = (rev_cnt == 4'd15) ? 4'd15 : 4'(rev_cnt + 4'd1);
    end
  end

  // Calibration FSM. All outputs are registered here. Reset and a low
  // enable both return the block to its initial code.
  always_ff @(posedge clk) begin
    if (!rstb || !enable) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      rev_cnt    <= 4'd0;
      prev_dir   <= 1'b0;
      prev_vld   <= 1'b0;
      code       <= INIT_C;
      bk         <= therm(INIT_C);
      lock       <= 1'b0;
      at_min     <= (INIT_C == 7'd0);
      at_max     <= (INIT_C == 7'd64);
    end else begin
      case (state)
        IDLE: begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_C;
          rev_cnt    <= 4'd0;
          prev_vld   <= 1'b0;
        end
        SETTLE: begin
          // The window closes on the edge where the counter reaches zero.
          if (settle_cnt <= 8'd1) begin
            settle_cnt <= 8'd0;
            state      <= lock ? LOCKED : SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        SAMPLE, LOCKED: begin
          if (pd_valid) begin
            code       <= code_step;
            bk         <= therm(code_step);
            at_min     <= (code_step == 7'd0);
            at_max     <= (code_step == 7'd64);
            rev_cnt    <= rev_step;
            settle_cnt <= SETTLE_C;
            state      <= SETTLE;
            if (sat) begin
              lock <= 1'b0;
            end else begin
              prev_dir <= pd_up;
              prev_vld <= 1'b1;
              if (rev_step == LOCK_C) lock <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_aibcr3_dcc_dlyctrl64.sv
// Bench for aibcr3_dcc_dlyctrl64: directed scenarios followed by random
// traffic. Every cycle is checked against a time-based reference model.
module tb_aibcr3_dcc_dlyctrl64;
  localparam int SETTLE_CYC = 8;
  localparam int LOCK_CNT   = 4;
  localparam int INIT_CODE  = 32;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0;
  logic        pd_valid = 1'b0;
  logic        pd_up = 1'b0;
  logic [63:0] bk;
  logic [6:0]  code;
  logic        lock;
  logic        at_min;
  logic        at_max;
  logic [1:0]  dbg_state;

  aibcr3_dcc_dlyctrl64 #(
    .SETTLE_CYC(SETTLE_CYC), .LOCK_CNT(LOCK_CNT), .INIT_CODE(INIT_CODE)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .pd_valid(pd_valid),
    .pd_up(pd_up), .bk(bk), .code(code), .lock(lock), .at_min(at_min),
    .at_max(at_max), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference model. Timing is expressed as the earliest edge at which a
  // sample may next be accepted.
  bit m_active = 0;
  int m_acc = 0;
  int m_code = INIT_CODE;
  bit m_lock = 0;
  int m_rev = 0;
  bit m_pv = 0;
  bit m_dir = 0;

  function automatic logic [63:0] m_bk();
    logic [63:0] r;
    if (m_code >= 64) r = '1;
    else r = (64'd1 << m_code) - 64'd1;
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit v, input bit up);
    if (!r || !en) begin
      m_active = 0; m_code = INIT_CODE; m_lock = 0; m_rev = 0; m_pv = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_acc = edge_n + SETTLE_CYC + 1;
    end else if (v && edge_n >= m_acc) begin
      m_acc = edge_n + SETTLE_CYC + 1;
      if ((up && m_code == 64) || (!up && m_code == 0)) begin
        m_rev = 0;
        m_lock = 0;
      end else begin
        m_code = up ? m_code + 1 : m_code - 1;
        if (m_pv && (m_dir != up)) m_rev = (m_rev >= 15) ? 15 : m_rev + 1;
        else m_rev = 0;
        m_pv = 1;
        m_dir = up;
        if (m_rev == LOCK_CNT) m_lock = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_all();
    chk("code", 64'(code), 64'(m_code));
    chk("bk", bk, m_bk());
    chk("lock", 64'(lock), 64'(m_lock));
    chk("at_min", 64'(at_min), 64'(m_code == 0));
    chk("at_max", 64'(at_max), 64'(m_code == 64));
    if (!m_active) chk("state_idle", 64'(dbg_state), 64'd0);
  endtask

  // driver: one clock cycle of stimulus, model step and full check
  task automatic cyc(input bit r, input bit en, input bit v, input bit up);
    @(negedge clk);
    rstb = r; enable = en; pd_valid = v; pd_up = up;
    @(posedge clk);
    model_edge(r, en, v, up);
    edge_n++;
    #1;
    check_all();
  endtask

  initial begin
    int bias;
    // reset held two cycles with enable and pd_valid active (reset wins)
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk("rst_code", 64'(code), 64'd32);
    chk("rst_bk", bk, 64'h0000_0000_FFFF_FFFF);
    chk("rst_lock", 64'(lock), 64'd0);
    chk("rst_idle", 64'(dbg_state), 64'd0);

    // settle timing with pd_valid held high
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 1);
    chk("settle_hold", 64'(code), 64'd32);
    cyc(1, 1, 1, 1);
    chk("first_step", 64'(code), 64'd33);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 1);
    chk("gap_hold", 64'(code), 64'd33);
    cyc(1, 1, 1, 1);
    chk("second_step", 64'(code), 64'd34);

    // up-saturation
    for (int i = 0; i < 400 && m_code < 64; i++) cyc(1, 1, 1, 1);
    chk("sat_code", 64'(code), 64'd64);
    chk("sat_at_max", 64'(at_max), 64'd1);
    for (int i = 0; i < 30; i++) cyc(1, 1, 1, 1);
    chk("sat_hold_code", 64'(code), 64'd64);
    chk("sat_hold_bk", bk, '1);

    // lock by alternating up/down around 32
    cyc(1, 0, 0, 0);
    chk("dis_code", 64'(code), 64'd32);
    for (int i = 0; i < 200 && !m_lock; i++) cyc(1, 1, 1, m_code == 32);
    chk("lock_set", 64'(lock), 64'd1);
    chk("lock_code", 64'(code), 64'd33);

    // lock at code 0, then lose it on a saturated down step
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 600 && m_code > 0; i++) cyc(1, 1, 1, 0);
    for (int i = 0; i < 200 && !m_lock; i++) cyc(1, 1, 1, m_code == 0);
    chk("lock0_set", 64'(lock), 64'd1);
    chk("lock0_code", 64'(code), 64'd0);
    for (int i = 0; i < 20 && m_lock; i++) cyc(1, 1, 1, 0);
    chk("lockloss_lock", 64'(lock), 64'd0);
    chk("lockloss_code", 64'(code), 64'd0);
    chk("lockloss_min", 64'(at_min), 64'd1);

    // disable mid-settle at code 40
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 200 && m_code < 40; i++) cyc(1, 1, 1, 1);
    chk("pre_dis_code", 64'(code), 64'd40);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 1);
    chk("middis_code", 64'(code), 64'd32);
    chk("middis_lock", 64'(lock), 64'd0);
    chk("middis_idle", 64'(dbg_state), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 0, i[0], 1);
    chk("middis_ignore", 64'(code), 64'd32);

    // random traffic with a drifting up/down bias
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) bias = (i % 1500 == 0) ? 50 : ((i % 1000 == 0) ? 95 : 5);
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 59) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) < bias);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aibcr3_dcc_dlyctrl64.md
AIBCR3_DCC_DLYCTRL64 -- requirements
Module: aibcr3_dcc_dlyctrl64

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 8: idle cycles after each code change before the next phase-detector sample is accepted (range 1..255).
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive direction reversals needed to declare lock (range 1..15).
REQ-003 SHALL have parameter INIT_CODE, default 32: code loaded on reset and when enable is low (range 0..64).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstb, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: enables calibration; low forces IDLE.
REQ-007 SHALL have port pd_valid, input, 1 bit: phase-detector result valid for one cycle.
REQ-008 SHALL have port pd_up, input, 1 bit: 1 means add one delay stage, 0 means remove one; qualified by pd_valid.
REQ-009 SHALL have port bk, output, 64 bits: thermometer control word for the 64-stage delay line, where bk[i]=1 iff i < code.
REQ-010 SHALL have port code, output, 7 bits: current stage count, 0..64.
REQ-011 SHALL have port lock, output, 1 bit: calibration locked.
REQ-012 SHALL have port at_min, output, 1 bit: code==0.
REQ-013 SHALL have port at_max, output, 1 bit: code==64.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and LOCKED.
REQ-015 SHALL move IDLE->SETTLE on the first cycle with enable=1, load the settle counter with SETTLE_CYC and clear the reversal counter and the previous-direction-valid flag.
REQ-016 SHALL, in SETTLE, decrement the settle counter each cycle, move to SAMPLE on the cycle it reaches 0, and ignore pd_valid.
REQ-017 SHALL, in SAMPLE or LOCKED with pd_valid=1, apply one step: code+1 if pd_up=1, else code-1; code, bk, at_min and at_max SHALL update on the same edge (1-cycle latency from pd_valid).
REQ-018 SHALL saturate the step: an up request at code=64 or a down request at code=0 leaves code unchanged, clears the reversal counter, and counts as neither a step nor a reversal.
REQ-019 SHALL count a reversal when an applied step's direction differs from the previous applied step's direction, with previous-direction-valid=1; the first step after IDLE only sets the previous direction.
REQ-020 SHALL clear the reversal counter on an applied step with the same direction as the previous one.
REQ-021 SHALL, when a step leaves reversals==LOCK_CNT, go from SAMPLE to LOCKED with lock=1 from the next cycle.
REQ-022 SHALL, after any applied or saturated step, reload the settle counter and return to SETTLE; the lock flag SHALL be retained across SETTLE once set.
REQ-023 SHALL, in LOCKED, keep tracking steps per REQ-017..020 and hold lock=1; lock SHALL clear only on a saturated step, on enable=0, or on reset.
REQ-024 SHALL, with enable=0 in any state, go to IDLE on the next edge with code=INIT_CODE, lock=0 and counters cleared, including mid-SETTLE.
REQ-025 SHALL ignore pd_valid in IDLE and SETTLE without queuing it.
REQ-026 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-027 SHALL never leave code outside 0..64, and SHALL keep bk a valid thermometer code at all times.

Reset
REQ-028 SHALL, with rstb=0 at a clk edge, set state=IDLE, code=INIT_CODE, bk lower INIT_CODE bits set (default bk=64'h0000_0000_FFFF_FFFF), lock=0, at_min=(INIT_CODE==0), at_max=(INIT_CODE==64), and clear all counters.
REQ-029 SHALL give reset priority over enable and pd_valid.
REQ-030 SHALL not change outputs asynchronously when rstb falls between clock edges.

Verification
REQ-031 SHALL cover reset: rstb=0 for 2 cycles, then release with enable=0 -> code=32, bk=64'h0000_0000_FFFF_FFFF, lock=0, state IDLE.
REQ-032 SHALL cover settle timing: enable=1 with pd_valid held at 1 -> no code change for 9 cycles (IDLE->SETTLE plus 8), first step one cycle after SAMPLE entry, then 8-cycle gaps.
REQ-033 SHALL cover up-saturation: pd_up=1 on every accepted sample from 32 -> code reaches 64 after 32 steps, at_max=1, further ups leave code=64 and bk=all ones.
REQ-034 SHALL cover lock: alternating up/down samples from 32 -> code 33,32,33,32,33, lock=1 after the 5th step (4 reversals).
REQ-035 SHALL cover lock loss: in LOCKED at code=0, a pd_up=0 sample -> code stays 0 and lock=0 next cycle.
REQ-036 SHALL cover mid-operation disable: enable dropped during SETTLE at code=40 -> next cycle code=32, lock=0, IDLE, and pd_valid pulses are ignored.
